// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   Holds the fetch FSM encoding, the reset fetch address and the
//   layout of the {pc, inst} bundle handed from fetch to decode.
package if_stage_pkg;

  // Fetch FSM: one instruction in flight, request -> response -> hold.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } fs_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam int          FS_TO_DS_W       = 64;

  // Instruction held for decode; pc in the upper half, inst in the lower.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

  // Sequential next PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Purpose: instruction fetch, owns the PC and drives the synchronous inst SRAM.
// Latency: request in S_REQ, fs_to_ds_valid two cycles later; one instruction per 3 cycles at best.
// Backpressure: the fetched instruction is held stable until ds_allowin; redirects drop it.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   inst_sram_*         SRAM read port; en/addr issue a read, rdata returns next cycle
//   ds_allowin          decode can accept the held instruction this cycle
//   br_taken/br_target  one-cycle redirect pulse and its target from execute
//   fs_to_ds_valid      fs_pc/fs_inst hold a valid instruction for decode
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,

  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,

  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  fs_state_e   state;
  logic [31:0] pc;
  logic        cancel;   // redirect seen while the current read was in flight
  fs_to_ds_t   fs_buf;
  logic        fs_vld;
  logic        en_q;

  // The read port is never written.
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'd0;
  assign inst_sram_addr  = pc;
  assign inst_sram_en    = en_q;

  assign fs_to_ds_valid  = fs_vld;
  assign fs_pc           = fs_buf.pc;
  assign fs_inst         = fs_buf.inst;

  // en_q is registered alongside the state: it is 1 exactly while in S_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      cancel <= 1'b0;
      fs_buf <= '0;
      fs_vld <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_taken) pc <= br_target;
          state <= S_REQ;
          en_q  <= 1'b1;
        end

        S_REQ: begin
          // The SRAM has already sampled the old pc; a redirect here only
          // marks the returning word as stale and retargets the PC.
          en_q  <= 1'b0;
          state <= S_RESP;
          if (br_taken) begin
            cancel <= 1'b1;
            pc     <= br_target;
          end
        end

        S_RESP: begin
          if (cancel || br_taken) begin
            // Stale word: discard and refetch. A redirect arriving now
            // supersedes any target latched in S_REQ.
            cancel <= 1'b0;
            if (br_taken) pc <= br_target;
            state <= S_REQ;
            en_q  <= 1'b1;
          end else begin
            fs_buf <= '{pc: pc, inst: inst_sram_rdata};
            fs_vld <= 1'b1;
            state  <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (ds_allowin) begin
            // Handshake: the instruction leaves even if a redirect arrives
            // in the same cycle; the redirect only chooses the next PC.
            fs_vld <= 1'b0;
            pc     <= br_taken ? br_target : seq_pc(pc);
            state  <= S_REQ;
            en_q   <= 1'b1;
          end else if (br_taken) begin
            fs_vld <= 1'b0;
            pc     <= br_target;
            state  <= S_REQ;
            en_q   <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by random traffic,
// checked by an event-level reference model and a delivery scoreboard.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc3a5_9e71;
  endfunction

  // Synchronous SRAM; garbage on rdata when no read was issued.
  always @(posedge clk) begin
    if (inst_sram_en === 1'b1) inst_sram_rdata <= mem_word(inst_sram_addr);
    else                       inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  bit          rst_prev = 0;
  bit          pend_vld = 0, pend_cancel = 0;
  bit          held = 0, exp_req = 0;
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] pend_pc, held_pc, held_inst;

  always @(negedge clk) begin
    bit   cur_req, new_due, mvalid, nx_req;
    exp_t e;
    cyc++;
    if (reset === 1'b1) begin
      // Everything in flight is abandoned; outputs are checked after release.
      exp_q.delete();
      pend_vld = 0;
      held     = 0;
      exp_req  = 0;
      rst_prev = 1;
    end else begin
      cur_req = exp_req;
      nx_req  = 0;
      if (rst_prev) begin
        check("rst_en",    {31'd0, inst_sram_en},   32'd0);
        check("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        check("rst_fs_pc", fs_pc,   32'd0);
        check("rst_fs_inst", fs_inst, 32'd0);
        check("rst_addr",  inst_sram_addr, RESET_PC);
        exp_next = RESET_PC;
        cur_req  = 0;
        nx_req   = 1;      // idle always proceeds to a request
      end

      check("sram_we",    {31'd0, inst_sram_we}, 32'd0);
      check("sram_wdata", inst_sram_wdata, 32'd0);
      check("sram_en",    {31'd0, inst_sram_en}, {31'd0, cur_req});
      if (inst_sram_en === 1'b1) check("fetch_addr", inst_sram_addr, exp_next);

      // Presentation to decode.
      new_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      mvalid  = new_due || held;
      check("fs_valid", {31'd0, fs_to_ds_valid}, {31'd0, mvalid});
      if (new_due) begin
        e = exp_q.pop_front();
        held_pc   = e.pc;
        held_inst = e.inst;
        if (fs_to_ds_valid === 1'b1) begin
          check("new_fs_pc",   fs_pc,   e.pc);
          check("new_fs_inst", fs_inst, e.inst);
        end
      end else if (held && fs_to_ds_valid === 1'b1) begin
        check("hold_fs_pc",   fs_pc,   held_pc);
        check("hold_fs_inst", fs_inst, held_inst);
      end

      // Response cycle of the previous request: survives only without redirect.
      if (pend_vld) begin
        if (pend_cancel || br_taken) nx_req = 1;
        else exp_q.push_back('{pc: pend_pc, inst: mem_word(pend_pc), due: cyc + 1});
        pend_vld = 0;
      end

      if (cur_req) begin
        pend_vld    = 1;
        pend_pc     = exp_next;
        pend_cancel = br_taken;
      end

      // Held instruction: consumed, dropped, or kept.
      held = 0;
      if (mvalid) begin
        if (ds_allowin) begin
          exp_next = held_pc + 32'd4;
          nx_req   = 1;
        end else if (br_taken) begin
          nx_req = 1;
        end else begin
          held = 1;
        end
      end
      if (br_taken) exp_next = br_target;   // latest redirect wins

      exp_req  = nx_req;
      rst_prev = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit a, input bit b, input logic [31:0] t);
    reset      = r;
    ds_allowin = a;
    br_taken   = b;
    br_target  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_en(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      if (inst_sram_en === 1'b1) seen = 1;
      else step(0, 1, 0, 32'd0);
    end
    if (!seen) begin
      tests++; errors++;
      $display("FAIL wait_en: no request within %0d cycles", maxc);
    end
  endtask

  task automatic run_until_valid(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      if (fs_to_ds_valid === 1'b1) seen = 1;
      else step(0, 1, 0, 32'd0);
    end
    if (!seen) begin
      tests++; errors++;
      $display("FAIL wait_valid: no instruction within %0d cycles", maxc);
    end
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'd0;
    inst_sram_rdata = 32'd0;

    // Reset, then free-running fetch with decode always ready.
    repeat (3) step(1, 1, 0, 32'd0);
    repeat (8) step(0, 1, 0, 32'd0);

    // Decode stalls in hold, then accepts.
    run_until_valid(10);
    repeat (5) step(0, 0, 0, 32'd0);
    repeat (4) step(0, 1, 0, 32'd0);

    // Redirect during the request: returned word dropped.
    run_until_en(10);
    step(0, 1, 1, 32'h1c00_0100);
    repeat (4) step(0, 1, 0, 32'd0);

    // Redirect during the response only.
    run_until_en(10);
    step(0, 1, 0, 32'd0);
    step(0, 1, 1, 32'h1c00_0140);
    repeat (4) step(0, 1, 0, 32'd0);

    // Redirects in both request and response: later target wins.
    run_until_en(10);
    step(0, 1, 1, 32'h1c00_0180);
    step(0, 1, 1, 32'h1c00_01c0);
    repeat (4) step(0, 1, 0, 32'd0);

    // Redirect in hold without handshake, then with handshake.
    run_until_valid(10);
    step(0, 0, 0, 32'd0);
    step(0, 0, 1, 32'h1c00_0200);
    run_until_valid(10);
    step(0, 1, 1, 32'h1c00_0300);
    repeat (4) step(0, 1, 0, 32'd0);

    // PC wrap past the top of the address space, with an unaligned target after.
    run_until_valid(10);
    step(0, 1, 1, 32'hffff_fffc);
    run_until_valid(10);
    step(0, 1, 0, 32'd0);
    repeat (4) step(0, 1, 0, 32'd0);
    run_until_valid(10);
    step(0, 1, 1, 32'h0000_1233);
    repeat (4) step(0, 1, 0, 32'd0);

    // Reset during the response, then redirect during idle.
    run_until_en(10);
    step(0, 1, 0, 32'd0);
    step(1, 1, 0, 32'd0);
    repeat (6) step(0, 1, 0, 32'd0);
    step(1, 1, 0, 32'd0);
    step(0, 1, 1, 32'h1c00_0400);
    repeat (6) step(0, 1, 0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, a, b;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 6) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hffff_fff0 + 32'($urandom_range(0, 15)))
                                      : 32'($urandom);
      step(r, a, b, t);
    end

    repeat (6) step(0, 1, 0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
